// File: rtl/dual_chamber_pacer_pkg.sv
// Shared encodings for the dual-chamber pacer: FSM states and pacing modes.
package pacer_pkg;

   typedef enum logic [2:0] {
      V_REFR  = 3'd0,
      A_WAIT  = 3'd1,
      A_PACE  = 3'd2,
      AV_WAIT = 3'd3,
      V_PACE  = 3'd4
   } pacer_state_e;

   localparam logic MODE_DDD = 1'b0;
   localparam logic MODE_VVI = 1'b1;

endpackage

// File: rtl/dual_chamber_pacer_if.sv
// Signal bundle between the sense front-end / programming registers (master)
// and the pacer core (slave).
//
// There is no valid/ready handshake here. Every signal is clk-synchronous and
// single-cycle:
// - sa/sv are level samples taken each cycle.
// - a_sense_evt/v_sense_evt are one-cycle strobes, valid in the same cycle as
//   the accepted sense.
// - pa/pv stay high for the whole pulse.
// - Interval inputs may change at any time and are only used at a load.
interface dual_chamber_pacer_if #(
   parameter int TW = 8
);
   logic          mode;
   logic [TW-1:0] va_interval;
   logic [TW-1:0] av_interval;
   logic [TW-1:0] refr_interval;
   logic          sa;
   logic          sv;
   logic          pa;
   logic          pv;
   logic          a_sense_evt;
   logic          v_sense_evt;
   logic [2:0]    state_o;

   modport master (
      output mode, va_interval, av_interval, refr_interval, sa, sv,
      input  pa, pv, a_sense_evt, v_sense_evt, state_o
   );

   modport slave (
      input  mode, va_interval, av_interval, refr_interval, sa, sv,
      output pa, pv, a_sense_evt, v_sense_evt, state_o
   );
endinterface

// File: rtl/dual_chamber_pacer_timer.sv
// Single down-counter shared by all pacer states.
// A load takes priority over counting. The count holds at zero, and expire
// is high while the count is zero.
module pacer_interval_timer #(
   parameter int TW = 8
) (
   input  logic          clk,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   output logic          expire
);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   // Next count: load, else decrement, saturating at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register. The owner asserts load during reset.
   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign expire = (cnt_q == '0);

endmodule

// File: rtl/dual_chamber_pacer.sv
// Programmable DDD/VVI pacing core.
// A five-state FSM sequences refractory, escape, AV delay and pace pulses.
// One shared interval timer is reloaded with (interval - 1) on every state
// entry.
module dual_chamber_pacer
   import pacer_pkg::*;
#(
   parameter int TW = 8,
   parameter int PW = 2
) (
   input logic                clk,
   input logic                rst,
   dual_chamber_pacer_if.slave bus
);

   localparam logic [TW-1:0] PW_LOAD = TW'(PW - 1);

   pacer_state_e  state_q;
   pacer_state_e  state_d;
   logic          load;
   logic [TW-1:0] load_val;
   logic          expire;

   // An interval of 0 behaves as 1, so its load value is 0.
   function automatic logic [TW-1:0] load_of(input logic [TW-1:0] iv);
      return (iv == '0) ? '0 : iv - 1'b1;
   endfunction

   pacer_interval_timer #(.TW(TW)) u_timer (
      .clk      (clk),
      .load     (load),
      .load_val (load_val),
      .expire   (expire)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= V_REFR;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and timer reload.
   // A sense is tested before expire, so a coincident sense suppresses the
   // pace pulse.
   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      load_val = load_of(bus.refr_interval);
      if (rst) begin
         state_d  = V_REFR;
         load     = 1'b1;
         load_val = load_of(bus.refr_interval);
      end else begin
         case (state_q)
            V_REFR: begin
               if (expire) begin
                  load     = 1'b1;
                  load_val = load_of(bus.va_interval);
                  state_d  = (bus.mode == MODE_VVI) ? AV_WAIT : A_WAIT;
               end
            end
            A_WAIT: begin
               if (bus.sa) begin
                  state_d  = AV_WAIT;
                  load     = 1'b1;
                  load_val = load_of(bus.av_interval);
               end else if (expire) begin
                  state_d  = A_PACE;
                  load     = 1'b1;
                  load_val = PW_LOAD;
               end
            end
            A_PACE: begin
               if (expire) begin
                  state_d  = AV_WAIT;
                  load     = 1'b1;
                  load_val = load_of(bus.av_interval);
               end
            end
            AV_WAIT: begin
               if (bus.sv) begin
                  state_d  = V_REFR;
                  load     = 1'b1;
                  load_val = load_of(bus.refr_interval);
               end else if (expire) begin
                  state_d  = V_PACE;
                  load     = 1'b1;
                  load_val = PW_LOAD;
               end
            end
            V_PACE: begin
               if (expire) begin
                  state_d  = V_REFR;
                  load     = 1'b1;
                  load_val = load_of(bus.refr_interval);
               end
            end
            default: begin
               state_d  = V_REFR;
               load     = 1'b1;
               load_val = load_of(bus.refr_interval);
            end
         endcase
      end
   end

   // Outputs decoded from the current state and the live sense inputs.
   always_comb begin
      bus.pa          = (state_q == A_PACE);
      bus.pv          = (state_q == V_PACE);
      bus.a_sense_evt = bus.sa & (state_q == A_WAIT);
      bus.v_sense_evt = bus.sv & (state_q == AV_WAIT);
      bus.state_o     = state_q;
   end

endmodule
